// File: rtl/wshb_if.sv
// Wishbone classic bus bundle between the frame reader (master) and the frame memory (slave).
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic [31:0] adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (input clk, rst, dat_sm, ack, err, rty,
                    output adr, cyc, stb, we, sel, dat_ms);
    modport slave  (input clk, rst, adr, cyc, stb, we, sel, dat_ms,
                    output dat_sm, ack, err, rty);
endinterface

// File: rtl/wb_frame_reader.sv
// Wishbone classic master streaming one frame of words into a fall-through FIFO.
// Define WB_FRAME_READER_ERR_EN to honour err/rty and expose the sticky err_flag output.
module wb_frame_reader #(
    parameter logic [31:0] BASE_ADR    = 32'h0,
    parameter int          FRAME_WORDS = 2048,
    parameter int          FIFO_DEPTH  = 16
) (
    wshb_if.master      wb_m,
    input  logic        start,
    input  logic        loop,
    output logic        busy,
    output logic [31:0] out_data,
    output logic        out_sof,
    output logic        out_valid,
    input  logic        out_ready
`ifdef WB_FRAME_READER_ERR_EN
    ,
    output logic        err_flag
`endif
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int LAST_I = FRAME_WORDS - 1;
    localparam logic [CW-1:0] LAST_C  = LAST_I[CW-1:0];
    localparam logic [AW:0]   DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic {IDLE, READ} state_t;
    typedef struct packed {
        logic        sof;
        logic [31:0] data;
    } fifo_word_t;

    logic clk, rst;
    assign clk = wb_m.clk;
    assign rst = wb_m.rst;

    state_t        state_q, state_d;
    logic          stb_q, stb_d;
    logic [31:0]   adr_q, adr_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef WB_FRAME_READER_ERR_EN
    logic          errf_q, errf_d;
`else
    logic          unused_resp;
    assign unused_resp = wb_m.err | wb_m.rty;
`endif

    fifo_word_t    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fcount, fcount_nxt;
    logic          push, pop, room, last_word;

    assign push       = stb_q & wb_m.ack;
    assign pop        = out_valid & out_ready;
    assign fcount_nxt = fcount + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    // Issue a request only when the word it returns is guaranteed a FIFO slot.
    assign room       = fcount_nxt < DEPTH_C;
    assign last_word  = (cnt_q == LAST_C);

    assign wb_m.adr    = adr_q;
    assign wb_m.cyc    = stb_q;
    assign wb_m.stb    = stb_q;
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = 4'hF;
    assign wb_m.dat_ms = 32'h0;

    assign busy      = (state_q == READ);
    assign out_valid = (fcount != '0);
    assign out_data  = out_valid ? mem[rd_ptr].data : 32'h0;
    assign out_sof   = out_valid ? mem[rd_ptr].sof : 1'b0;
`ifdef WB_FRAME_READER_ERR_EN
    assign err_flag  = errf_q;
`endif

    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
`ifdef WB_FRAME_READER_ERR_EN
        errf_d  = errf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    adr_d   = BASE_ADR;
                    cnt_d   = '0;
                    stb_d   = room;
`ifdef WB_FRAME_READER_ERR_EN
                    errf_d  = 1'b0;
`endif
                end
            end
            READ: begin
                if (push) begin
                    adr_d = adr_q + 32'd4;
                    cnt_d = cnt_q + CW'(1);
                    stb_d = room;
                    if (last_word) begin
                        if (loop) begin
                            adr_d = BASE_ADR;
                            cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                            stb_d   = 1'b0;
                        end
                    end
                end
`ifdef WB_FRAME_READER_ERR_EN
                else if (stb_q && wb_m.err) begin
                    state_d = IDLE;
                    stb_d   = 1'b0;
                    errf_d  = 1'b1;
                end else if (stb_q && wb_m.rty) begin
                    stb_d = 1'b0;
                end
`endif
                else if (!stb_q) begin
                    stb_d = room;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            adr_q   <= BASE_ADR;
            cnt_q   <= '0;
`ifdef WB_FRAME_READER_ERR_EN
            errf_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
`ifdef WB_FRAME_READER_ERR_EN
            errf_q  <= errf_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fcount <= fcount_nxt;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{sof: (cnt_q == '0), data: wb_m.dat_sm};
    end
endmodule

// File: tb/tb_wb_frame_reader.sv
// Scoreboard bench: an 8-word reader and a 32-word reader against random-wait-state slaves.
module tb_wb_frame_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wshb_if bus8  (.clk(clk), .rst(rst));
    wshb_if bus32 (.clk(clk), .rst(rst));

    logic        start8 = 0, loop8 = 0, ready8 = 0, busy8, sof8, valid8;
    logic        start32 = 0, loop32 = 0, ready32 = 0, busy32, sof32, valid32;
    logic [31:0] data8, data32;
    logic        err8_en = 0, err8_used = 0;
`ifdef WB_FRAME_READER_ERR_EN
    logic        err_flag8, err_flag32;
`endif

    wb_frame_reader #(.BASE_ADR(32'h0), .FRAME_WORDS(8), .FIFO_DEPTH(16)) u8 (
        .wb_m(bus8), .start(start8), .loop(loop8), .busy(busy8), .out_data(data8),
        .out_sof(sof8), .out_valid(valid8), .out_ready(ready8)
`ifdef WB_FRAME_READER_ERR_EN
        , .err_flag(err_flag8)
`endif
    );
    wb_frame_reader #(.BASE_ADR(32'h0), .FRAME_WORDS(32), .FIFO_DEPTH(16)) u32 (
        .wb_m(bus32), .start(start32), .loop(loop32), .busy(busy32), .out_data(data32),
        .out_sof(sof32), .out_valid(valid32), .out_ready(ready32)
`ifdef WB_FRAME_READER_ERR_EN
        , .err_flag(err_flag32)
`endif
    );

    assign bus8.rty  = 1'b0;
    assign bus32.rty = 1'b0;

    // Slaves: word i holds i*0x01010101; ack one or more cycles after stb.
    always @(posedge clk) begin
        if (rst) begin
            bus8.ack <= 1'b0; bus8.err <= 1'b0; bus8.dat_sm <= 32'h0;
        end else begin
            bus8.ack <= 1'b0; bus8.err <= 1'b0;
            if (bus8.cyc && bus8.stb && !bus8.ack && !bus8.err && $urandom_range(0, 3) != 0) begin
                if (err8_en && !err8_used && bus8.adr == 32'h8) begin
                    bus8.err  <= 1'b1;
                    err8_used <= 1'b1;
                end else begin
                    bus8.ack    <= 1'b1;
                    bus8.dat_sm <= (bus8.adr >> 2) * 32'h01010101;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            bus32.ack <= 1'b0; bus32.err <= 1'b0; bus32.dat_sm <= 32'h0;
        end else begin
            bus32.ack <= 1'b0; bus32.err <= 1'b0;
            if (bus32.cyc && bus32.stb && !bus32.ack && $urandom_range(0, 3) != 0) begin
                bus32.ack    <= 1'b1;
                bus32.dat_sm <= (bus32.adr >> 2) * 32'h01010101;
            end
        end
    end

    int n_chk = 0, n_pass = 0;
    logic [32:0] q8[$], q32[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Pop scoreboard on every transfer; a pop at this negedge matches the DUT pop at the next posedge.
    always @(negedge clk) begin
        if (!rst && valid8 && ready8) begin
            if (q8.size() == 0) chk("out8 unexpected", {sof8, data8}, 33'h0);
            else chk("out8 word", {sof8, data8}, q8.pop_front());
        end
        if (!rst && valid32 && ready32) begin
            if (q32.size() == 0) chk("out32 unexpected", {sof32, data32}, 33'h0);
            else chk("out32 word", {sof32, data32}, q32.pop_front());
        end
    end

    task automatic push8(input int first, input int n, input int fw);
        for (int i = first; i < first + n; i++)
            q8.push_back({(i % fw) == 0, 32'(i % fw) * 32'h01010101});
    endtask

    task automatic drive_step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start8();
        drive_step(); start8 = 1'b1;
        drive_step(); start8 = 1'b0;
    endtask

    // Watch n acks on bus8; checks stb/adr hold while a request is pending and counts cyc=0 cycles.
    task automatic watch8(input int n, output int gaps);
        int seen = 0, cyc_n = 0;
        logic ps = 1'b0, pa = 1'b0;
        logic [31:0] padr = 32'h0;
        gaps = 0;
        while (seen < n && cyc_n < 2000) begin
            @(negedge clk); cyc_n++;
            if (ps && !pa) begin
                chk("stb hold", bus8.stb, 1);
                chk("adr hold", bus8.adr, padr);
            end
            if (!bus8.cyc) gaps++;
            if (bus8.stb && bus8.ack) seen++;
            ps = bus8.stb; pa = bus8.ack; padr = bus8.adr;
        end
        chk("ack count", seen, n);
    endtask

    task automatic drain8();
        int n = 0;
        while ((q8.size() != 0 || valid8) && n < 1000) begin @(negedge clk); n++; end
        chk("drain8 left", q8.size(), 0);
    endtask

    initial begin
        int gaps, cyc_hi, acks, n;
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst cyc", bus8.cyc, 0);       chk("rst stb", bus8.stb, 0);
        chk("rst we", bus8.we, 0);         chk("rst sel", bus8.sel, 4'hF);
        chk("rst adr", bus8.adr, 32'h0);   chk("rst dat_ms", bus8.dat_ms, 0);
        chk("rst busy", busy8, 0);         chk("rst valid", valid8, 0);
        chk("rst sof", sof8, 0);           chk("rst data", data8, 0);
        drive_step(); rst = 1'b0;
        cyc_hi = 0;
        repeat (10) begin @(negedge clk); if (bus8.cyc || bus32.cyc) cyc_hi++; end
        chk("idle cyc", cyc_hi, 0);

        // Single frame, consumer always ready
        ready8 = 1'b1;
        push8(0, 8, 8);
        pulse_start8();
        watch8(8, gaps);
        @(negedge clk);
        chk("busy after last", busy8, 0);
        chk("cyc after last", bus8.cyc, 0);
        drain8();

        // Backpressure: FIFO fills, reader stops, then resumes
        drive_step(); start32 = 1'b1;
        drive_step(); start32 = 1'b0;
        acks = 0;
        repeat (200) begin @(negedge clk); if (bus32.stb && bus32.ack) acks++; end
        chk("bp acks", acks, 16);
        chk("bp stb", bus32.stb, 0);
        chk("bp valid", valid32, 1);
        for (int i = 0; i < 32; i++) q32.push_back({i == 0, 32'(i) * 32'h01010101});
        drive_step(); ready32 = 1'b1;
        n = 0;
        while ((q32.size() != 0 || busy32) && n < 2000) begin
            @(negedge clk); n++;
            if (bus32.stb && bus32.ack) acks++;
        end
        chk("bp total acks", acks, 32);
        chk("bp left", q32.size(), 0);

        // Looping frames, then stop after the current frame
        loop8 = 1'b1;
        push8(0, 24, 8);
        pulse_start8();
        watch8(20, gaps);
        chk("loop gaps a", gaps, 0);
        drive_step(); loop8 = 1'b0;
        watch8(4, gaps);
        chk("loop gaps b", gaps, 0);
        @(negedge clk);
        chk("loop end busy", busy8, 0);
        drain8();

        // Reset mid-frame, then a clean restart
        drive_step(); ready8 = 1'b0;
        pulse_start8();
        watch8(3, gaps);
        drive_step(); rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("abort cyc", bus8.cyc, 0);   chk("abort stb", bus8.stb, 0);
        chk("abort valid", valid8, 0);   chk("abort busy", busy8, 0);
        drive_step(); rst = 1'b0; ready8 = 1'b1;
        push8(0, 8, 8);
        pulse_start8();
        @(negedge clk);
        chk("restart adr", bus8.adr, 32'h0);
        watch8(8, gaps);
        drain8();

        // Slave error on word 2
        err8_en = 1'b1;
`ifdef WB_FRAME_READER_ERR_EN
        push8(0, 2, 8);
        pulse_start8();
        n = 0;
        while (!(bus8.stb && bus8.err) && n < 500) begin @(negedge clk); n++; end
        chk("err seen", bus8.stb && bus8.err, 1);
        @(negedge clk);
        chk("err cyc", bus8.cyc, 0);
        chk("err flag", err_flag8, 1);
        chk("err busy", busy8, 0);
        drain8();
        push8(0, 8, 8);
        pulse_start8();
        chk("err flag clear", err_flag8, 0);
        watch8(8, gaps);
        drain8();
`else
        push8(0, 8, 8);
        pulse_start8();
        watch8(8, gaps);
        chk("err injected", err8_used, 1);
        drain8();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
